// File: rtl/tp1_montre_oci_dct_pkg.sv
// Shared constants, state encoding and helpers for the OCI debug-trace packer.
package tp1_montre_oci_dct_pkg;

    localparam int FRAME_W = 2;
    localparam int NFRAMES = 15;
    localparam int BUF_W   = FRAME_W * NFRAMES;
    localparam int CNT_W   = 4;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NFRAMES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } dct_state_t;

    // Write one frame into slot idx of the packing buffer, other slots untouched.
    function automatic logic [BUF_W-1:0] insert_frame(
        input logic [BUF_W-1:0]   buf_in,
        input logic [CNT_W-1:0]   idx,
        input logic [FRAME_W-1:0] frame
    );
        logic [BUF_W-1:0] r;
        r = buf_in;
        for (int i = 0; i < NFRAMES; i++) begin
            if (idx == i[CNT_W-1:0]) begin
                r[FRAME_W*i +: FRAME_W] = frame;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tp1_montre_oci_dct_outreg.sv
// Single-entry valid/ready holding register for the packed output word.
// Handshake: a word moves when valid & ready are both high at a rising edge;
// while out_valid & !out_ready the held word is stable. in_ready is high when
// the slot is empty or is being emptied this cycle.
module tp1_montre_oci_dct_outreg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load a new word when the slot frees, otherwise drop valid once consumed.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/tp1_montre_cpu_oci_dct_packer.sv
// Packs 2-bit trace frames into 30-bit words with a frame count and sequences
// the end-of-test drain (RUN -> DRAIN -> DONE).
// Optional macro DCT_PACKER_OVF_EN adds frm_drop / ovf_count for frames
// offered while the packer could not take them in RUN.
// Frame handshake: a frame is taken when frm_valid & frm_ready at a rising edge.
module tp1_montre_cpu_oci_dct_packer
    import tp1_montre_oci_dct_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               frm_valid,
    input  logic [FRAME_W-1:0] frm_data,
    output logic               frm_ready,
    input  logic               flush_req,
    input  logic               end_req,
    output logic               dct_valid,
    input  logic               dct_ready,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               test_ending,
    output logic               test_has_ended,
    output dct_state_t         dbg_state
`ifdef DCT_PACKER_OVF_EN
    ,
    output logic               frm_drop,
    output logic [15:0]        ovf_count
`endif
);

    dct_state_t         state_q, state_d;
    logic [BUF_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               close_pend_q, close_pend_d;

    logic               frm_accept;
    logic [BUF_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               flush_eff;
    logic               push;
    logic               slot_free;
    logic [CNT_W+BUF_W-1:0] out_word;

    assign dbg_state      = state_q;
    assign test_ending    = (state_q == ST_DRAIN);
    assign test_has_ended = (state_q == ST_DONE);
    assign {dct_count, dct_buffer} = out_word;

    // Accumulator datapath: accept, then close the word when full or flushed.
    always_comb begin
        frm_ready    = (state_q == ST_RUN) && (acc_cnt_q != FULL_CNT) && !close_pend_q;
        frm_accept   = frm_valid && frm_ready;
        acc_next     = frm_accept ? insert_frame(acc_q, acc_cnt_q, frm_data) : acc_q;
        cnt_next     = acc_cnt_q + CNT_W'(frm_accept);
        flush_eff    = ((state_q == ST_RUN) && flush_req) || (state_q == ST_DRAIN);
        push         = (cnt_next != '0) &&
                       ((cnt_next == FULL_CNT) || close_pend_q || flush_eff);
        acc_d        = acc_next;
        acc_cnt_d    = cnt_next;
        close_pend_d = push;
        if (push && slot_free) begin
            acc_d        = '0;
            acc_cnt_d    = '0;
            close_pend_d = 1'b0;
        end
    end

    // End-of-test sequencing; DONE is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (end_req) state_d = ST_DRAIN;
            ST_DRAIN: if ((acc_cnt_q == '0) && !dct_valid) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            close_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            close_pend_q <= close_pend_d;
        end
    end

    tp1_montre_oci_dct_outreg #(
        .W (CNT_W + BUF_W)
    ) u_outreg (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push),
        .in_data   ({cnt_next, acc_next}),
        .in_ready  (slot_free),
        .out_valid (dct_valid),
        .out_data  (out_word),
        .out_ready (dct_ready)
    );

`ifdef DCT_PACKER_OVF_EN
    logic [15:0] ovf_q, ovf_d;

    assign ovf_count = ovf_q;

    // Count frames refused while running, saturating.
    always_comb begin
        frm_drop = frm_valid && !frm_ready && (state_q == ST_RUN);
        ovf_d    = ovf_q;
        if (frm_drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    // Overflow counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_tp1_montre_cpu_oci_dct_packer.sv
// Bench for the trace packer: directed scenarios with literal expectations
// plus a long randomized run against a queue-based reference model.
module tb_tp1_montre_cpu_oci_dct_packer;
  import tp1_montre_oci_dct_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frm_valid = 1'b0;
  logic [1:0]  frm_data = 2'b00;
  logic        frm_ready;
  logic        flush_req = 1'b0;
  logic        end_req = 1'b0;
  logic        dct_valid;
  logic        dct_ready = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  dct_state_t  dbg_state;
`ifdef DCT_PACKER_OVF_EN
  logic        frm_drop;
  logic [15:0] ovf_count;
`endif

  always #5 clk = ~clk;

  tp1_montre_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .frm_valid      (frm_valid),
    .frm_data       (frm_data),
    .frm_ready      (frm_ready),
    .flush_req      (flush_req),
    .end_req        (end_req),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .dbg_state      (dbg_state)
`ifdef DCT_PACKER_OVF_EN
    ,
    .frm_drop       (frm_drop),
    .ovf_count      (ovf_count)
`endif
  );

  // ---------------- reference model ----------------
  // Frames waiting to be packed, a pending-close flag, the one output slot,
  // and a phase number: 0 running, 1 draining, 2 ended.
  int          m_q[$];
  bit          m_pend;
  bit          m_ov;
  logic [29:0] m_buf;
  logic [3:0]  m_cnt;
  int          m_ph;
  logic [15:0] m_ovf;

  // Scoreboard of words the model produced, in delivery order.
  logic [33:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  function automatic bit m_ready();
    return (m_ph == 0) && (m_q.size() < 15) && !m_pend;
  endfunction

  function automatic logic [29:0] pack(input int q[$]);
    logic [29:0] w;
    w = '0;
    foreach (q[i]) w = w | (30'(q[i]) << (2 * i));
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("frm_ready", 64'(frm_ready), 64'(m_ready()));
    chk("dct_valid", 64'(dct_valid), 64'(m_ov));
    if (m_ov) begin
      chk("dct_buffer", 64'(dct_buffer), 64'(m_buf));
      chk("dct_count", 64'(dct_count), 64'(m_cnt));
    end
    chk("test_ending", 64'(test_ending), 64'(m_ph == 1));
    chk("test_has_ended", 64'(test_has_ended), 64'(m_ph == 2));
`ifdef DCT_PACKER_OVF_EN
    chk("ovf_count", 64'(ovf_count), 64'(m_ovf));
    chk("frm_drop", 64'(frm_drop), 64'((m_ph == 0) && frm_valid && !m_ready()));
`endif
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit v, input logic [1:0] d, input bit fl,
                       input bit er, input bit rdy, input bit rs);
    int          q2[$];
    bit          acc, free, fe, want;
    bit          n_ov, n_pend;
    int          n_ph;
    logic [29:0] n_buf;
    logic [3:0]  n_cnt;
    logic [15:0] n_ovf;
    bit          push_w;

    frm_valid = v; frm_data = d; flush_req = fl; end_req = er;
    dct_ready = rdy; reset = rs;

    // Word leaving the DUT this edge must be the oldest expected word.
    if (!rs && dct_valid && dct_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", 64'({dct_count, dct_buffer}), 64'(0));
      end else begin
        chk("sb_word", 64'({dct_count, dct_buffer}), 64'(exp_q.pop_front()));
      end
    end

    q2 = m_q; n_ov = m_ov; n_buf = m_buf; n_cnt = m_cnt; n_ph = m_ph;
    n_ovf = m_ovf; n_pend = m_pend; push_w = 1'b0;
    if (rs) begin
      q2.delete(); n_ov = 0; n_pend = 0; n_ph = 0; n_ovf = '0;
    end else begin
      acc  = v && m_ready();
      if (acc) q2.push_back(int'(d));
      free = !m_ov || rdy;
      fe   = ((m_ph == 0) && fl) || (m_ph == 1);
      want = (q2.size() == 15) || m_pend || (fe && q2.size() > 0);
      if ((m_ph == 0) && v && !m_ready() && (m_ovf != 16'hFFFF)) n_ovf = m_ovf + 16'd1;
      if ((m_ph == 0) && er) n_ph = 1;
      else if ((m_ph == 1) && (m_q.size() == 0) && !m_ov) n_ph = 2;
      if (want && free) begin
        n_buf = pack(q2); n_cnt = 4'(q2.size()); n_ov = 1; n_pend = 0;
        q2.delete(); push_w = 1'b1;
      end else begin
        n_ov = free ? 1'b0 : m_ov;
        n_pend = want;
      end
    end

    @(posedge clk);
    m_q = q2; m_ov = n_ov; m_buf = n_buf; m_cnt = n_cnt; m_ph = n_ph;
    m_ovf = n_ovf; m_pend = n_pend;
    if (rs) exp_q.delete();
    if (push_w) exp_q.push_back({n_cnt, n_buf});
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    cycle(0, 2'b00, 0, 0, 0, 1);
    cycle(0, 2'b00, 0, 0, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  f[31];
    logic [29:0] exp1, exp2;
    bit          saw5;

    m_ph = 0; m_pend = 0; m_ov = 0; m_buf = '0; m_cnt = '0; m_ovf = '0;

    // Reset state.
    do_reset();
    cycle(0, 2'b00, 0, 0, 0, 0);
    chk("rst_frm_ready", 64'(frm_ready), 64'(1));
    chk("rst_dct_valid", 64'(dct_valid), 64'(0));
    chk("rst_dct_buffer", 64'(dct_buffer), 64'(0));
    chk("rst_dct_count", 64'(dct_count), 64'(0));
    chk("rst_ending", 64'({test_ending, test_has_ended}), 64'(0));

    // Three frames then flush.
    cycle(1, 2'b01, 0, 0, 1, 0);
    cycle(1, 2'b10, 0, 0, 1, 0);
    cycle(1, 2'b11, 0, 0, 1, 0);
    chk("t1_not_yet", 64'(dct_valid), 64'(0));
    cycle(0, 2'b00, 1, 0, 1, 0);
    chk("t1_valid", 64'(dct_valid), 64'(1));
    chk("t1_count", 64'(dct_count), 64'(3));
    chk("t1_buffer", 64'(dct_buffer), 64'(30'h0000_0039));
    cycle(0, 2'b00, 0, 0, 1, 0);

    // Fifteen frames of 2'b10 back to back.
    for (int i = 0; i < 15; i++) begin
      chk("t2_ready_held", 64'(frm_ready), 64'(1));
      cycle(1, 2'b10, 0, 0, 1, 0);
    end
    chk("t2_valid", 64'(dct_valid), 64'(1));
    chk("t2_count", 64'(dct_count), 64'(15));
    chk("t2_buffer", 64'(dct_buffer), 64'(30'h2AAA_AAAA));
    chk("t2_ready_after", 64'(frm_ready), 64'(1));
    cycle(0, 2'b00, 0, 0, 1, 0);

    // Backpressure: 31 frames, two full words stored.
    do_reset();
    exp1 = '0; exp2 = '0;
    for (int i = 0; i < 31; i++) f[i] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 15; i++) begin
      exp1 = exp1 | (30'(f[i]) << (2 * i));
      exp2 = exp2 | (30'(f[i + 15]) << (2 * i));
    end
    for (int i = 0; i < 31; i++) begin
      cycle(1, f[i], 0, 0, 0, 0);
      if (i == 29) chk("t3_ready_low_30", 64'(frm_ready), 64'(0));
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 2'b00, 0, 0, 0, 0);
      chk("t3_hold_buf", 64'(dct_buffer), 64'(exp1));
      chk("t3_hold_cnt", 64'(dct_count), 64'(15));
    end
    cycle(0, 2'b00, 0, 0, 1, 0);
    chk("t3_w2_valid", 64'(dct_valid), 64'(1));
    chk("t3_w2_buf", 64'(dct_buffer), 64'(exp2));
    chk("t3_w2_cnt", 64'(dct_count), 64'(15));
    cycle(0, 2'b00, 0, 0, 1, 0);
    chk("t3_drained", 64'(dct_valid), 64'(0));

    // Flush with nothing accumulated.
    do_reset();
    cycle(0, 2'b00, 1, 0, 1, 0);
    chk("t4_empty_flush", 64'(dct_valid), 64'(0));
    cycle(0, 2'b00, 1, 0, 0, 0);
    chk("t4_empty_flush2", 64'(dct_valid), 64'(0));

    // Five frames then end of test.
    for (int i = 0; i < 5; i++) cycle(1, 2'(i), 0, 0, 1, 0);
    cycle(0, 2'b00, 0, 1, 1, 0);
    chk("t5_ending", 64'(test_ending), 64'(1));
    chk("t5_ready_low", 64'(frm_ready), 64'(0));
    saw5 = 0;
    for (int i = 0; i < 20 && !test_has_ended; i++) begin
      if (dct_valid && dct_count == 4'd5) saw5 = 1;
      cycle(0, 2'b00, 0, 0, 1, 0);
    end
    chk("t5_done_in_budget", 64'(test_has_ended), 64'(1));
    chk("t5_word5_seen", 64'(saw5), 64'(1));
    chk("t5_ending_clear", 64'(test_ending), 64'(0));
    for (int i = 0; i < 4; i++) cycle(1, 2'b11, 1, 1, 1, 0);
    chk("t5_done_sticky", 64'({test_has_ended, frm_ready, dct_valid}), 64'(3'b100));

`ifdef DCT_PACKER_OVF_EN
    // Drops counted while full, then reset mid-drain.
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1, 2'($urandom_range(0, 3)), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 2'b01, 0, 0, 0, 0);
    chk("ovf_four", 64'(ovf_count), 64'(4));
    cycle(0, 2'b00, 0, 1, 0, 0);
    chk("ovf_drain", 64'(test_ending), 64'(1));
    cycle(0, 2'b00, 0, 0, 0, 1);
    chk("ovf_rst_cnt", 64'(ovf_count), 64'(0));
    chk("ovf_rst_valid", 64'(dct_valid), 64'(0));
    chk("ovf_rst_run", 64'({test_ending, frm_ready}), 64'(2'b01));
`endif

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 249) == 0,
            (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            $urandom_range(0, 399) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
